// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: state encoding,
// special register numbers and the default starvation limit.
package regfile_write_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_t;

   localparam logic [4:0] REG_ZERO           = 5'd0;
   localparam logic [4:0] STATUS_REG_DEFAULT = 5'd30;
   localparam int         MAX_WAIT_DEFAULT   = 4;

endpackage

// File: rtl/regfile_write_arbiter_pend_buf.sv
// One-entry holding register for a multdiv result waiting for the write port.
// Capture has priority over clear; the arbiter never raises both together.
module wbarb_pend_buf
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              capture,
   input  logic              clear,
   input  logic [4:0]        in_dest,
   input  logic [DATA_W-1:0] in_data,
   output logic              valid,
   output logic [4:0]        dest,
   output logic [DATA_W-1:0] data
);

   always_ff @(posedge clock) begin
      if (!reset) begin
         valid <= 1'b0;
         dest  <= REG_ZERO;
         data  <= '0;
      end else if (capture) begin
         valid <= 1'b1;
         dest  <= in_dest;
         data  <= in_data;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between writeback and the
// multdiv unit. Optional macro WBARB_BYPASS_EN writes idle-cycle results directly.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int         DATA_W     = 32,
   parameter int         MAX_WAIT   = MAX_WAIT_DEFAULT,
   parameter int         WAIT_W     = 3,
   parameter logic [4:0] STATUS_REG = STATUS_REG_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wb_we,
   input  logic [4:0]        wb_reg,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              md_valid,
   output logic              md_ready,
   input  logic [4:0]        md_reg,
   input  logic [DATA_W-1:0] md_data,
   input  logic              md_exception,
   output logic              stall_wb,
   output logic              pend_valid,
   output logic [4:0]        pend_reg,
   output logic              ctrl_writeEnable,
   output logic [4:0]        ctrl_writeReg,
   output logic [DATA_W-1:0] data_writeReg
);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   arb_state_t        state, state_next;
   logic [WAIT_W-1:0] wait_cnt, wait_next;
   logic              transfer, capture, clear, wb_active, write_en;
   logic [4:0]        md_dest;
   logic [DATA_W-1:0] pend_data;

   wbarb_pend_buf #(.DATA_W(DATA_W)) u_pend_buf (
      .clock   (clock),
      .reset   (reset),
      .capture (capture),
      .clear   (clear),
      .in_dest (md_dest),
      .in_data (md_data),
      .valid   (pend_valid),
      .dest    (pend_reg),
      .data    (pend_data)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
      end
   end

   assign stall_wb = (state == ST_FORCE);

   // Grant priority: forced drain, then writeback, then a waiting result.
   // A writeback to register 0 is a bubble and leaves the port free.
   always_comb begin
      state_next    = state;
      wait_next     = wait_cnt;
      capture       = 1'b0;
      clear         = 1'b0;
      write_en      = 1'b0;
      ctrl_writeReg = REG_ZERO;
      data_writeReg = '0;

      md_dest   = md_exception ? STATUS_REG : md_reg;
      md_ready  = reset & ~pend_valid & (state != ST_FORCE);
      transfer  = md_valid & md_ready;
      wb_active = wb_we & (wb_reg != REG_ZERO);

      if (state == ST_FORCE) begin
         write_en      = (pend_reg != REG_ZERO);
         ctrl_writeReg = pend_reg;
         data_writeReg = pend_data;
         clear         = 1'b1;
         state_next    = ST_IDLE;
         wait_next     = '0;
      end else if (wb_active) begin
         write_en      = 1'b1;
         ctrl_writeReg = wb_reg;
         data_writeReg = wb_data;
         if (state == ST_PEND) begin
            // A younger writeback to the same register makes the buffered result dead.
            if (pend_valid && (pend_reg != REG_ZERO) && (wb_reg == pend_reg)) begin
               clear      = 1'b1;
               state_next = ST_IDLE;
               wait_next  = '0;
            end else if (wait_cnt == WAIT_LAST) begin
               state_next = ST_FORCE;
            end else begin
               wait_next = wait_cnt + WAIT_W'(1);
            end
         end
      end else if (pend_valid) begin
         write_en      = (pend_reg != REG_ZERO);
         ctrl_writeReg = pend_reg;
         data_writeReg = pend_data;
         clear         = 1'b1;
         state_next    = ST_IDLE;
         wait_next     = '0;
      end

      if (transfer) begin
`ifdef WBARB_BYPASS_EN
         if (!wb_active) begin
            write_en      = (md_dest != REG_ZERO);
            ctrl_writeReg = md_dest;
            data_writeReg = md_data;
         end else begin
            capture    = 1'b1;
            state_next = ST_PEND;
            wait_next  = '0;
         end
`else
         capture    = 1'b1;
         state_next = ST_PEND;
         wait_next  = '0;
`endif
      end

      ctrl_writeEnable = write_en & reset;
   end

endmodule
